perceptron_cmd_ctrl: RTL

PERCEPTRON_CMD_CTRL -- requirements
Module: perceptron_cmd_ctrl

---
 rtl/perceptron_cmd_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/perceptron_cmd_ctrl.sv
// Byte-command controller for a two-input perceptron: decodes UART opcodes,
// stages/commits weight and input pairs, and streams responses to the UART.
module perceptron_cmd_ctrl #(
    parameter int FP_WIDTH       = 16,
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    input  logic                tx_busy,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    input  logic [FP_WIDTH-1:0] result,
    output logic [FP_WIDTH-1:0] weight1,
    output logic [FP_WIDTH-1:0] weight2,
    output logic [FP_WIDTH-1:0] input1,
    output logic [FP_WIDTH-1:0] input2,
    output logic                busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

    localparam logic [7:0] OP_READ  = 8'd5;
    localparam logic [7:0] OP_WR_W  = 8'd50;
    localparam logic [7:0] OP_WR_IN = 8'd51;
    localparam logic [7:0] RSP_READ = 8'd100;
    localparam logic [7:0] RSP_OK   = 8'd101;
    localparam logic [7:0] RSP_ERR  = 8'd102;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_PAYLOAD,
        S_COMMIT,
        S_TX_LOAD,
        S_TX_WAIT_HI,
        S_TX_WAIT_LO
    } state_t;

    state_t                    state_q, state_d;
    logic                      tgt_q, tgt_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [2:0]                len_q, len_d;
    logic [TW-1:0]             to_q, to_d;
    logic [2*FP_WIDTH-1:0]     stage_q, stage_d;
    logic [7:0][7:0]           buf_q, buf_d;
    logic [FP_WIDTH-1:0]       w1_q, w1_d, w2_q, w2_d;
    logic [FP_WIDTH-1:0]       in1_q, in1_d, in2_q, in2_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tgt_q   <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
            to_q    <= '0;
            stage_q <= '0;
            buf_q   <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            to_q    <= to_d;
            stage_q <= stage_d;
            buf_q   <= buf_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        to_d    = to_q;
        stage_d = stage_q;
        buf_d   = buf_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        in1_d   = in1_q;
        in2_d   = in2_q;

        unique case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    cnt_d = '0;
                    unique case (rx_data)
                        OP_READ: begin
                            buf_d[0] = RSP_READ;
                            buf_d[1] = w1_q[15:8];
                            buf_d[2] = w1_q[7:0];
                            buf_d[3] = w2_q[15:8];
                            buf_d[4] = w2_q[7:0];
                            buf_d[5] = result[15:8];
                            buf_d[6] = result[7:0];
                            len_d    = 3'd7;
                            state_d  = S_TX_LOAD;
                        end
                        OP_WR_W, OP_WR_IN: begin
                            tgt_d   = (rx_data == OP_WR_IN);
                            to_d    = '0;
                            state_d = S_RX_PAYLOAD;
                        end
                        default: begin
                            buf_d[0] = RSP_ERR;
                            len_d    = 3'd1;
                            state_d  = S_TX_LOAD;
                        end
                    endcase
                end
            end
            S_RX_PAYLOAD: begin
                // A byte landing on the expiry cycle still counts.
                if (rx_valid) begin
                    to_d    = '0;
                    stage_d = {stage_q[2*FP_WIDTH-9:0], rx_data};
                    if (cnt_q == 3'd3) begin
                        cnt_d   = '0;
                        state_d = S_COMMIT;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (to_q >= TO_LIMIT) begin
                    stage_d  = '0;
                    cnt_d    = '0;
                    buf_d[0] = RSP_ERR;
                    len_d    = 3'd1;
                    state_d  = S_TX_LOAD;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            S_COMMIT: begin
                if (tgt_q) begin
                    in1_d = stage_q[2*FP_WIDTH-1:FP_WIDTH];
                    in2_d = stage_q[FP_WIDTH-1:0];
                end else begin
                    w1_d = stage_q[2*FP_WIDTH-1:FP_WIDTH];
                    w2_d = stage_q[FP_WIDTH-1:0];
                end
                buf_d[0] = RSP_OK;
                len_d    = 3'd1;
                cnt_d    = '0;
                state_d  = S_TX_LOAD;
            end
            S_TX_LOAD: begin
                state_d = S_TX_WAIT_HI;
            end
            S_TX_WAIT_HI: begin
                if (tx_busy) state_d = S_TX_WAIT_LO;
            end
            S_TX_WAIT_LO: begin
                if (!tx_busy) begin
                    if (cnt_q + 3'd1 < len_q) begin
                        cnt_d   = cnt_q + 3'd1;
                        state_d = S_TX_LOAD;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tx_start = (state_q == S_TX_LOAD) || (state_q == S_TX_WAIT_HI);
    assign tx_data  = buf_q[cnt_q];
    assign busy     = (state_q != S_IDLE);
    assign weight1  = w1_q;
    assign weight2  = w2_q;
    assign input1   = in1_q;
    assign input2   = in2_q;

endmodule
